uart_rom_loader: RTL and testbench



---
 rtl/uart_rom_loader_pkg.sv | 28 ++
 rtl/uart_rom_loader_if.sv | 21 ++
 rtl/uart_rom_loader_rx_core.sv | 149 ++++++++++++++
 rtl/uart_rom_loader.sv | 152 +++++++++++++++
 tb/tb_uart_rom_loader.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rom_loader_pkg.sv
// Shared definitions for the UART ROM loader slice.
// Contents:
//   DEF_CLK_FREQ / DEF_UART_BPS  default clock and baud rate
//   rx_state_e                   receiver FSM state encoding
//   calc_baud_div                clock cycles per UART bit
// Build option: UART_PARITY_EN adds the PARITY state (even parity, 8E1 frames).
package uart_rom_loader_pkg;

  localparam int DEF_CLK_FREQ = 50000000;
  localparam int DEF_UART_BPS = 9600;

  // Receiver states; PARITY exists only in parity-enabled builds.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Clock cycles per bit; integer division, callers require a result >= 4.
  function automatic int calc_baud_div(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_rom_loader_if.sv
// ROM write-port bundle driven by the loader.
// Signals:
//   rom_erase_en  one-cycle request for a full ROM erase
//   rom_wr_en     one-cycle write strobe
//   rom_wr_addr   byte address of the current write
//   rom_wr_data   assembled word
// Modports: master (loader side), slave (ROM side).
interface uart_rom_loader_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              rom_erase_en;
  logic              rom_wr_en;
  logic [ADDR_W-1:0] rom_wr_addr;
  logic [DATA_W-1:0] rom_wr_data;

  modport master (output rom_erase_en, rom_wr_en, rom_wr_addr, rom_wr_data);
  modport slave  (input  rom_erase_en, rom_wr_en, rom_wr_addr, rom_wr_data);

endinterface

// File: rtl/uart_rom_loader_rx_core.sv
// uart_rx_core: serial receiver front end of the ROM loader.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   rx_i             asynchronous serial line, idles high
//   byte_valid_o     one-cycle pulse, byte_data_o holds a good byte
//   byte_data_o      received byte (LSB arrives first)
//   frame_err_o      one-cycle pulse on a bad stop bit (or parity mismatch)
//   start_ok_o       one-cycle pulse when the start bit survives its mid-bit check
//   active_o         high whenever the FSM is outside IDLE
// Build option: UART_PARITY_EN inserts an even-parity bit between data and stop.
module uart_rx_core
  import uart_rom_loader_pkg::*;
#(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o,
  output logic       start_ok_o,
  output logic       active_o
);

  localparam int             CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_DIV / 2 - 1);

  logic             sync1_q, sync2_q, sync3_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             fall, mid, last, stop_ok;
`ifdef UART_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  // Two flops bring rx into the clock domain; the third keeps the previous
  // synchronised value so a 1->0 transition can be spotted. Reset to the idle
  // level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign fall = sync3_q & ~sync2_q;
  assign mid  = (cnt_q == CNT_MID);
  assign last = (cnt_q == CNT_LAST);

`ifdef UART_PARITY_EN
  assign stop_ok = sync2_q & ~par_err_q;
`else
  assign stop_ok = sync2_q;
`endif

  // State register plus the datapath registers the FSM steers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef UART_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  // Next-state logic. The baud counter free-runs outside IDLE and samples are
  // taken at the bit centre. STOP hands back to IDLE at its centre so the
  // next start edge can already be seen during the second half of the stop bit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (state_q == ST_IDLE || last) ? '0 : cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    start_ok_o   = 1'b0;
`ifdef UART_PARITY_EN
    par_err_d    = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (mid) begin
          if (sync2_q) state_d = ST_IDLE;
          else         start_ok_o = 1'b1;
        end
        if (last) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (mid) shift_d = {sync2_q, shift_q[7:1]};
        if (last) begin
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      ST_PARITY: begin
        if (mid)  par_err_d = sync2_q ^ (^shift_q);
        if (last) state_d   = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (mid) begin
          if (stop_ok) byte_valid_o = 1'b1;
          else         frame_err_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) cnt_d = '0;
  end

  assign byte_data_o = shift_q;
  assign active_o    = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: turns a UART byte stream into ROM word writes.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   uart_rx       asynchronous serial input, idles high
//   rom           uart_rom_loader_if.master: erase pulse, write strobe,
//                 auto-incrementing byte address, assembled word
//   frame_err_o   one-cycle pulse on a framing/parity error or inter-byte timeout
//   busy_o        frame in flight or word partially assembled
// Build option: UART_PARITY_EN selects 8E1 frames instead of 8N1.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int CLK_FREQ       = DEF_CLK_FREQ,
  parameter int UART_BPS       = DEF_UART_BPS,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_W         = 32,
  parameter int BIG_ENDIAN     = 1,
  parameter int TIMEOUT_BITS   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               uart_rx,
  uart_rom_loader_if.master  rom,
  output logic               frame_err_o,
  output logic               busy_o
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, UART_BPS);
  localparam int DATA_W   = 8 * BYTES_PER_WORD;
  localparam int IDX_W    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_BITS - 1);

  logic              byte_valid, core_ferr, start_ok, rx_active, timeout_hit;
  logic [7:0]        byte_data;
  logic [DATA_W-1:0] word_q, word_d, base;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic              erase_q, erase_d, erased_q, erased_d;
  logic              ferr_q, ferr_d;
  logic [CNT_W-1:0]  tcyc_q, tcyc_d;
  logic [31:0]       tbits_q, tbits_d;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (uart_rx),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (core_ferr),
    .start_ok_o   (start_ok),
    .active_o     (rx_active)
  );

  // Loader state register; everything clears on reset, including the
  // one-erase-per-reset flag so a fresh stream erases again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q   <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      wr_en_q  <= 1'b0;
      erase_q  <= 1'b0;
      erased_q <= 1'b0;
      ferr_q   <= 1'b0;
      tcyc_q   <= '0;
      tbits_q  <= '0;
    end else begin
      word_q   <= word_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wr_en_q  <= wr_en_d;
      erase_q  <= erase_d;
      erased_q <= erased_d;
      ferr_q   <= ferr_d;
      tcyc_q   <= tcyc_d;
      tbits_q  <= tbits_d;
    end
  end

  // Word assembly, addressing, erase and timeout. A new word starts from a
  // cleared base so little-endian OR-ing never picks up stale bytes. The
  // address steps one cycle after the write strobe, so the strobe carries the
  // address the word belongs to. The timeout only runs while the receiver
  // idles with a partial word, so it can never coincide with byte_valid.
  always_comb begin
    base        = (idx_q == '0) ? '0 : word_q;
    word_d      = word_q;
    data_d      = data_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    wr_en_d     = 1'b0;
    erase_d     = 1'b0;
    erased_d    = erased_q;
    ferr_d      = core_ferr;
    tcyc_d      = tcyc_q;
    tbits_d     = tbits_q;
    timeout_hit = 1'b0;

    if (wr_en_q) addr_d = addr_q + ADDR_W'(BYTES_PER_WORD);

    if (start_ok && addr_q == '0 && idx_q == '0 && !erased_q) begin
      erase_d  = 1'b1;
      erased_d = 1'b1;
    end

    if (rx_active || idx_q == '0) begin
      tcyc_d  = '0;
      tbits_d = '0;
    end else if (tcyc_q == CNT_LAST) begin
      tcyc_d = '0;
      if (tbits_q == TO_LAST) begin
        timeout_hit = 1'b1;
        tbits_d     = '0;
      end else begin
        tbits_d = tbits_q + 32'd1;
      end
    end else begin
      tcyc_d = tcyc_q + 1'b1;
    end

    if (byte_valid) begin
      if (BIG_ENDIAN != 0) word_d = (base << 8) | DATA_W'(byte_data);
      else                 word_d = base | (DATA_W'(byte_data) << (8 * idx_q));
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        wr_en_d = 1'b1;
        data_d  = word_d;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end else if (timeout_hit) begin
      idx_d  = '0;
      word_d = '0;
      ferr_d = 1'b1;
    end
  end

  assign rom.rom_erase_en = erase_q;
  assign rom.rom_wr_en    = wr_en_q;
  assign rom.rom_wr_addr  = addr_q;
  assign rom.rom_wr_data  = data_q;
  assign frame_err_o      = ferr_q;
  assign busy_o           = rx_active | (idx_q != '0);

endmodule

// File: tb/tb_uart_rom_loader.sv
`timescale 1ns/1ps
module tb_uart_rom_loader;

  localparam int CLK_FREQ = 1000000;
  localparam int UART_BPS = 100000;
  localparam int BAUD_DIV = 10;
  localparam int BPW      = 4;
  localparam int TO_BITS  = 32;

  typedef logic [63:0] wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rx = 1'b1;
  logic ferrBig, busyBig, ferrLit, busyLit;

  int checks = 0;
  int failures = 0;

  wr_t obsBig[$], obsLit[$], expBig[$], expLit[$];
  int eraseBig = 0, eraseLit = 0, ferrCntBig = 0, ferrCntLit = 0;

  logic [7:0]  pend[$];
  logic [31:0] expAddr = 0;
  bit          expErased = 0;
  int          expErase = 0;
  int          expFerr = 0;

  always #5 clk = ~clk;

  uart_rom_loader_if #(.ADDR_W(32), .DATA_W(32)) romBig ();
  uart_rom_loader_if #(.ADDR_W(32), .DATA_W(32)) romLit ();

  uart_rom_loader #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .BYTES_PER_WORD(BPW),
                    .ADDR_W(32), .BIG_ENDIAN(1), .TIMEOUT_BITS(TO_BITS)) dutBig (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rom(romBig),
    .frame_err_o(ferrBig), .busy_o(busyBig));

  uart_rom_loader #(.CLK_FREQ(CLK_FREQ), .UART_BPS(UART_BPS), .BYTES_PER_WORD(BPW),
                    .ADDR_W(32), .BIG_ENDIAN(0), .TIMEOUT_BITS(TO_BITS)) dutLit (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .rom(romLit),
    .frame_err_o(ferrLit), .busy_o(busyLit));

  // Record every strobe the two loaders produce, sampled mid-cycle.
  always @(negedge clk) begin
    if (romBig.rom_wr_en === 1'b1) obsBig.push_back({romBig.rom_wr_addr, romBig.rom_wr_data});
    if (romLit.rom_wr_en === 1'b1) obsLit.push_back({romLit.rom_wr_addr, romLit.rom_wr_data});
    if (romBig.rom_erase_en === 1'b1) eraseBig++;
    if (romLit.rom_erase_en === 1'b1) eraseLit++;
    if (ferrBig === 1'b1) ferrCntBig++;
    if (ferrLit === 1'b1) ferrCntLit++;
  end

  // Bound the whole run in case the design never goes quiet.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value with the value the bench expects.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model of one frame: erase rule, byte collection and word packing.
  task automatic modelFrame(input logic [7:0] b, input bit good);
    logic [31:0] wb, wl;
    if (!expErased && expAddr == 0 && pend.size() == 0) begin
      expErased = 1;
      expErase++;
    end
    if (!good) begin
      expFerr++;
    end else begin
      pend.push_back(b);
      if (pend.size() == BPW) begin
        wb = 0;
        wl = 0;
        for (int i = 0; i < BPW; i++) begin
          wb = wb * 256 + 32'(pend[i]);
          wl = wl + (32'(pend[i]) << (8 * i));
        end
        expBig.push_back({expAddr, wb});
        expLit.push_back({expAddr, wl});
        expAddr = expAddr + BPW;
        pend.delete();
      end
    end
  endtask

  // Drive one UART frame (start, 8 data LSB first, optional parity, stop,
  // one idle bit) and update the model.
  task automatic applyStimulus(input logic [7:0] b, input bit stopBit);
    modelFrame(b, stopBit);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    uart_rx = ^b;
    repeat (BAUD_DIV) @(negedge clk);
`endif
    uart_rx = stopBit;
    repeat (BAUD_DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  // Hold the line idle; a long enough gap with a partial word is a timeout.
  task automatic idleBits(input int n);
    if (n >= TO_BITS + 2 && pend.size() != 0) begin
      pend.delete();
      expFerr++;
    end
    repeat (n * BAUD_DIV) @(negedge clk);
  endtask

  task automatic sendRandom(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1);
  endtask

  // Drain and compare the write logs of both loaders.
  task automatic compareWrites(input string tag);
    checkOutput({tag, "_nwrBig"}, 64'(obsBig.size()), 64'(expBig.size()));
    checkOutput({tag, "_nwrLit"}, 64'(obsLit.size()), 64'(expLit.size()));
    for (int i = 0; i < obsBig.size() && i < expBig.size(); i++)
      checkOutput({tag, "_wrBig"}, obsBig[i], expBig[i]);
    for (int i = 0; i < obsLit.size() && i < expLit.size(); i++)
      checkOutput({tag, "_wrLit"}, obsLit[i], expLit[i]);
    obsBig.delete();
    obsLit.delete();
    expBig.delete();
    expLit.delete();
  endtask

  task automatic checkStep(input string tag);
    compareWrites(tag);
    checkOutput({tag, "_eraseBig"}, 64'(eraseBig), 64'(expErase));
    checkOutput({tag, "_eraseLit"}, 64'(eraseLit), 64'(expErase));
    checkOutput({tag, "_ferrBig"}, 64'(ferrCntBig), 64'(expFerr));
    checkOutput({tag, "_ferrLit"}, 64'(ferrCntLit), 64'(expFerr));
    checkOutput({tag, "_addrBig"}, 64'(romBig.rom_wr_addr), 64'(expAddr));
    checkOutput({tag, "_addrLit"}, 64'(romLit.rom_wr_addr), 64'(expAddr));
    checkOutput({tag, "_busyBig"}, 64'(busyBig), 64'(pend.size() != 0));
    checkOutput({tag, "_busyLit"}, 64'(busyLit), 64'(pend.size() != 0));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_eraseBig"}, 64'(romBig.rom_erase_en), 64'd0);
    checkOutput({tag, "_wrEnBig"},  64'(romBig.rom_wr_en), 64'd0);
    checkOutput({tag, "_addrBig"},  64'(romBig.rom_wr_addr), 64'd0);
    checkOutput({tag, "_dataBig"},  64'(romBig.rom_wr_data), 64'd0);
    checkOutput({tag, "_ferrBig"},  64'(ferrBig), 64'd0);
    checkOutput({tag, "_busyBig"},  64'(busyBig), 64'd0);
    checkOutput({tag, "_eraseLit"}, 64'(romLit.rom_erase_en), 64'd0);
    checkOutput({tag, "_wrEnLit"},  64'(romLit.rom_wr_en), 64'd0);
    checkOutput({tag, "_addrLit"},  64'(romLit.rom_wr_addr), 64'd0);
    checkOutput({tag, "_dataLit"},  64'(romLit.rom_wr_data), 64'd0);
    checkOutput({tag, "_ferrLit"},  64'(ferrLit), 64'd0);
    checkOutput({tag, "_busyLit"},  64'(busyLit), 64'd0);
  endtask

  initial begin
    logic [7:0] first[4];
    bit busySeen;
    first[0] = 8'h12;
    first[1] = 8'h34;
    first[2] = 8'h56;
    first[3] = 8'h78;

    $display("[TB] reset");
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    checkReset("rstHeld");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkReset("rstDone");

    $display("[TB] first word 12 34 56 78");
    for (int i = 0; i < 4; i++) applyStimulus(first[i], 1'b1);
    repeat (3) @(negedge clk);
    checkStep("firstWord");

    $display("[TB] two more random words");
    sendRandom(8);
    repeat (3) @(negedge clk);
    checkStep("moreWords");

    $display("[TB] start-bit glitch");
    busySeen = 0;
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busyBig === 1'b1) busySeen = 1;
    end
    checkOutput("glitchBusySeen", 64'(busySeen), 64'd1);
    repeat (30) @(negedge clk);
    checkStep("glitch");

    $display("[TB] bad stop bit then a full word");
    applyStimulus(8'($urandom_range(0, 255)), 1'b0);
    idleBits(2);
    checkStep("badStop");
    sendRandom(4);
    repeat (3) @(negedge clk);
    checkStep("afterBadStop");

    $display("[TB] partial word timeout");
    sendRandom(2);
    checkStep("partial");
    idleBits(TO_BITS + 8);
    checkStep("timeout");
    sendRandom(4);
    repeat (3) @(negedge clk);
    checkStep("afterTimeout");

    $display("[TB] reset in the middle of byte 3");
    sendRandom(2);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    uart_rx = 1'b1;
    pend.delete();
    expAddr = 0;
    expErased = 0;
    repeat (5) @(negedge clk);
    checkReset("midReset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    sendRandom(4);
    repeat (3) @(negedge clk);
    checkStep("afterReset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
